// File: rtl/hps_design_pll_seq_pkg.sv
// Shared types for the fabric PLL reset sequencer.
// State encoding and retry counter width.
package hps_design_pll_seq_pkg;

  localparam int RETRY_CNT_W = 3;
  localparam logic [RETRY_CNT_W-1:0] RETRY_SAT = '1;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN,
    FAIL
  } seq_state_e;

  function automatic logic [RETRY_CNT_W-1:0] retry_inc(
    input logic [RETRY_CNT_W-1:0] v
  );
    return (v == RETRY_SAT) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/hps_design_pll_reset_seq_sync2.sv
// Two-flop synchronizer, async active-high reset to 0.
// Brings pll_locked into the refclk domain.
module hps_design_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/hps_design_pll_reset_seq.sv
// PLL power-up / recovery sequencer with staggered reset release.
// Optional PLL_SEQ_LOSS_CNT_EN adds a saturating lock-loss counter.
module hps_design_pll_reset_seq
  import hps_design_pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3,
  parameter int N_OUT         = 2,
  parameter int STAGGER       = 8
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   restart,
  output logic                   pll_rst,
  output logic [N_OUT-1:0]       rst_out,
  output logic                   ready,
  output logic                   fail,
  output logic [RETRY_CNT_W-1:0] retry_cnt
`ifdef PLL_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0]             loss_cnt
`endif
);

  localparam int PH_A =
    (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int PH_MAX = (PH_A > STAGGER) ? PH_A : STAGGER;
  localparam int PH_W = $clog2(PH_MAX + 1);
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int IX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [PH_W-1:0] RST_LAST = PH_W'(RST_CYCLES - 1);
  localparam logic [PH_W-1:0] STB_LAST = PH_W'(STABLE_CYCLES - 1);
  localparam logic [PH_W-1:0] STG_LAST = PH_W'(STAGGER - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_SAT   = TO_W'(LOCK_TIMEOUT);
  localparam logic [IX_W-1:0] IX_LAST  = IX_W'(N_OUT - 1);

  seq_state_e             state_q;
  logic [PH_W-1:0]        ph_q;
  logic [TO_W-1:0]        to_q;
  logic [IX_W-1:0]        ix_q;
  logic                   pll_rst_q;
  logic [N_OUT-1:0]       rst_out_q;
  logic                   ready_q;
  logic                   fail_q;
  logic [RETRY_CNT_W-1:0] retry_q;

  logic lk_s;
  logic loss;
  logic [IX_W-1:0] ix_nxt;
  logic [TO_W-1:0] to_inc;

  hps_design_sync2 u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d_i (pll_locked),
    .q_o (lk_s)
  );

  assign loss   = !lk_s && (state_q == RELEASE || state_q == RUN);
  assign ix_nxt = ix_q + 1'b1;
  assign to_inc = (to_q == TO_SAT) ? to_q : to_q + 1'b1;

  // Releases shift zeros in from bit 0, so bit order falls out of the shift.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= PLL_RST;
      ph_q      <= '0;
      to_q      <= '0;
      ix_q      <= '0;
      pll_rst_q <= 1'b1;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
      retry_q   <= '0;
    end else if (restart) begin
      state_q   <= PLL_RST;
      ph_q      <= '0;
      to_q      <= '0;
      ix_q      <= '0;
      pll_rst_q <= 1'b1;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
      retry_q   <= '0;
    end else if (loss) begin
      state_q   <= PLL_RST;
      ph_q      <= '0;
      ix_q      <= '0;
      pll_rst_q <= 1'b1;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
    end else begin
      unique case (state_q)
        PLL_RST: begin
          if (ph_q == RST_LAST) begin
            state_q   <= WAIT_LOCK;
            ph_q      <= '0;
            to_q      <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          to_q <= to_inc;
          if (lk_s) begin
            state_q <= STABLE;
            ph_q    <= '0;
          end else if (to_q >= TO_LAST) begin
            pll_rst_q <= 1'b1;
            ph_q      <= '0;
            if (int'(retry_q) < MAX_RETRY) begin
              retry_q <= retry_inc(retry_q);
              state_q <= PLL_RST;
            end else begin
              state_q <= FAIL;
              fail_q  <= 1'b1;
            end
          end
        end
        STABLE: begin
          to_q <= to_inc;
          if (!lk_s) begin
            state_q <= WAIT_LOCK;
            ph_q    <= '0;
          end else if (ph_q == STB_LAST) begin
            ph_q      <= '0;
            ix_q      <= '0;
            rst_out_q <= rst_out_q << 1;
            if (N_OUT == 1) begin
              state_q <= RUN;
              ready_q <= 1'b1;
              retry_q <= '0;
            end else begin
              state_q <= RELEASE;
            end
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        RELEASE: begin
          if (ph_q == STG_LAST) begin
            ph_q      <= '0;
            ix_q      <= ix_nxt;
            rst_out_q <= rst_out_q << 1;
            if (ix_nxt == IX_LAST) begin
              state_q <= RUN;
              ready_q <= 1'b1;
              retry_q <= '0;
            end
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        RUN: begin
          ready_q <= 1'b1;
        end
        FAIL: begin
          pll_rst_q <= 1'b1;
          rst_out_q <= '1;
          fail_q    <= 1'b1;
        end
        default: begin
          state_q   <= PLL_RST;
          ph_q      <= '0;
          pll_rst_q <= 1'b1;
          rst_out_q <= '1;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [7:0] loss_q;

  // Survives restart on purpose: only a hard reset clears the history.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      loss_q <= '0;
    end else if (!restart && loss && loss_q != 8'hFF) begin
      loss_q <= loss_q + 1'b1;
    end
  end

  assign loss_cnt = loss_q;
`endif

  assign pll_rst   = pll_rst_q;
  assign rst_out   = rst_out_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_hps_design_pll_reset_seq.sv
// Self-checking bench for hps_design_pll_reset_seq.
// Reference model tracks time-in-mode and derives outputs from it.
module tb_hps_design_pll_reset_seq;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 5;
  localparam int MAX_RETRY     = 2;
  localparam int N_OUT         = 2;
  localparam int STAGGER       = 3;
  localparam int VW            = N_OUT + 6;

  localparam int M_PR  = 0;
  localparam int M_WL  = 1;
  localparam int M_ST  = 2;
  localparam int M_REL = 3;
  localparam int M_RUN = 4;
  localparam int M_FL  = 5;

  logic             refclk = 1'b0;
  logic             rst;
  logic             pll_locked;
  logic             restart;
  logic             pll_rst;
  logic [N_OUT-1:0] rst_out;
  logic             ready;
  logic             fail;
  logic [2:0]       retry_cnt;
`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [7:0]       loss_cnt;
`endif

  always #5 refclk = ~refclk;

  hps_design_pll_reset_seq #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRY    (MAX_RETRY),
    .N_OUT        (N_OUT),
    .STAGGER      (STAGGER)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .restart   (restart),
    .pll_rst   (pll_rst),
    .rst_out   (rst_out),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt)
`ifdef PLL_SEQ_LOSS_CNT_EN
    ,
    .loss_cnt  (loss_cnt)
`endif
  );

  int checks = 0;
  int passed = 0;

  int m_mode, m_age, m_to, m_stab, m_retry, m_loss;
  bit m_pll_rst, m_ready, m_fail;
  bit [N_OUT-1:0] m_ro;
  bit hist[$];

  wire [VW-1:0] obs = {pll_rst, rst_out, ready, fail, retry_cnt};

  function automatic logic [VW-1:0] expv();
    return {m_pll_rst, m_ro, m_ready, m_fail, 3'(m_retry)};
  endfunction

  // Bit i is released once the release phase is i*STAGGER cycles old.
  function automatic bit [N_OUT-1:0] held_mask(int age);
    bit [N_OUT-1:0] r;
    for (int i = 0; i < N_OUT; i++) r[i] = !(i * STAGGER <= age);
    return r;
  endfunction

  task automatic model_reset();
    m_mode = M_PR; m_age = 0; m_to = 0; m_stab = 0;
    m_retry = 0; m_loss = 0;
    m_pll_rst = 1; m_ready = 0; m_fail = 0; m_ro = '1;
    hist.delete();
  endtask

  task automatic go_pll_rst();
    m_mode = M_PR; m_age = 0; m_pll_rst = 1;
    m_ro = '1; m_ready = 0;
  endtask

  task automatic model_step(input bit lk_raw, input bit rs);
    bit lk;
    lk = (hist.size() >= 2) ? hist[hist.size() - 2] : 1'b0;
    hist.push_back(lk_raw);
    if (rs) begin
      go_pll_rst();
      m_fail = 0; m_retry = 0;
    end else if (!lk && (m_mode == M_REL || m_mode == M_RUN)) begin
      go_pll_rst();
      if (m_loss < 255) m_loss++;
    end else begin
      case (m_mode)
        M_PR: begin
          m_age++;
          if (m_age == RST_CYCLES) begin
            m_mode = M_WL; m_to = 0; m_pll_rst = 0;
          end
        end
        M_WL: begin
          if (lk) begin
            m_mode = M_ST; m_stab = 0;
          end else if (m_to + 1 >= LOCK_TIMEOUT) begin
            if (m_retry < MAX_RETRY) begin
              m_retry = (m_retry < 7) ? m_retry + 1 : 7;
              go_pll_rst();
            end else begin
              m_mode = M_FL; m_fail = 1; m_pll_rst = 1;
            end
          end
          m_to++;
        end
        M_ST: begin
          m_to++;
          if (!lk) begin
            m_mode = M_WL; m_stab = 0;
          end else begin
            m_stab++;
            if (m_stab == STABLE_CYCLES) begin
              m_mode = M_REL; m_age = 0; m_ro = held_mask(0);
            end
          end
        end
        M_REL: begin
          m_age++;
          m_ro = held_mask(m_age);
          if (m_age == (N_OUT - 1) * STAGGER) begin
            m_mode = M_RUN; m_ready = 1; m_retry = 0;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    model_step(pll_locked, restart);
    #1;
  endtask

  task automatic do_reset();
    @(posedge refclk);
    #2 rst = 1'b1;
    restart = 1'b0;
    pll_locked = 1'b0;
    model_reset();
    @(posedge refclk);
    @(posedge refclk);
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== {1'b1, {N_OUT{1'b1}}, 5'b0})
      $display("FAIL reset_vals: got %b want %b", obs,
               {1'b1, {N_OUT{1'b1}}, 5'b0});
    else passed++;
  endtask

  task automatic test_bringup();
    int t0, t1;
    t0 = -1; t1 = -1;
    do_reset();
    for (int c = 0; c < 32; c++) begin
      tick();
      if (c == RST_CYCLES + 1) pll_locked = 1'b1;
      checks++;
      if (obs !== expv())
        $display("FAIL bringup c%0d: got %b want %b", c, obs, expv());
      else passed++;
      if (t0 < 0 && rst_out[0] === 1'b0) t0 = c;
      if (t1 < 0 && rst_out[1] === 1'b0) t1 = c;
    end
    checks++;
    if (t1 - t0 !== STAGGER)
      $display("FAIL bringup_stagger: got %0d want %0d", t1 - t0, STAGGER);
    else passed++;
    checks++;
    if ({ready, rst_out, retry_cnt} !== {1'b1, {N_OUT{1'b0}}, 3'd0})
      $display("FAIL bringup_final: got %b want %b",
               {ready, rst_out, retry_cnt}, {1'b1, {N_OUT{1'b0}}, 3'd0});
    else passed++;
  endtask

  task automatic test_glitch();
    bit hit;
    hit = 0;
    do_reset();
    pll_locked = 1'b1;
    for (int c = 0; c < 60 && !hit; c++) begin
      tick();
      checks++;
      if (obs !== expv())
        $display("FAIL glitch_pre c%0d: got %b want %b", c, obs, expv());
      else passed++;
      hit = (m_mode == M_ST && m_stab == 3);
    end
    checks++;
    if (!hit) $display("FAIL glitch_reach: got 0 want 1");
    else passed++;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    for (int c = 0; c < 25; c++) begin
      tick();
      checks++;
      if (obs !== expv())
        $display("FAIL glitch c%0d: got %b want %b", c, obs, expv());
      else passed++;
    end
    checks++;
    if (ready !== 1'b1) $display("FAIL glitch_ready: got %b want 1", ready);
    else passed++;
  endtask

  task automatic test_fail_restart();
    do_reset();
    for (int c = 0; c < 90; c++) begin
      tick();
      checks++;
      if (obs !== expv())
        $display("FAIL nolock c%0d: got %b want %b", c, obs, expv());
      else passed++;
    end
    checks++;
    if ({fail, pll_rst, retry_cnt} !== {2'b11, 3'(MAX_RETRY)})
      $display("FAIL fail_state: got %b want %b",
               {fail, pll_rst, retry_cnt}, {2'b11, 3'(MAX_RETRY)});
    else passed++;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++;
    if ({fail, pll_rst, retry_cnt} !== 5'b01000)
      $display("FAIL fail_restart: got %b want 01000",
               {fail, pll_rst, retry_cnt});
    else passed++;
    pll_locked = 1'b1;
    for (int c = 0; c < 25; c++) begin
      tick();
      checks++;
      if (obs !== expv())
        $display("FAIL after_restart c%0d: got %b want %b", c, obs, expv());
      else passed++;
    end
  endtask

  task automatic test_loss_in_run();
    pll_locked = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (obs !== expv())
        $display("FAIL loss c%0d: got %b want %b", c, obs, expv());
      else passed++;
    end
    checks++;
    if ({pll_rst, rst_out, ready} !== {1'b1, {N_OUT{1'b1}}, 1'b0})
      $display("FAIL loss_state: got %b want %b", {pll_rst, rst_out, ready},
               {1'b1, {N_OUT{1'b1}}, 1'b0});
    else passed++;
`ifdef PLL_SEQ_LOSS_CNT_EN
    checks++;
    if (loss_cnt !== 8'(m_loss))
      $display("FAIL loss_cnt: got %0d want %0d", loss_cnt, m_loss);
    else passed++;
`endif
  endtask

  task automatic test_restart_on_timeout();
    bit hit;
    hit = 0;
    do_reset();
    for (int c = 0; c < 60 && !hit; c++) begin
      tick();
      checks++;
      if (obs !== expv())
        $display("FAIL rto_pre c%0d: got %b want %b", c, obs, expv());
      else passed++;
      hit = (m_mode == M_WL && m_to + 1 >= LOCK_TIMEOUT);
    end
    checks++;
    if (!hit) $display("FAIL rto_reach: got 0 want 1");
    else passed++;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++;
    if ({pll_rst, retry_cnt} !== 4'b1000)
      $display("FAIL rto_state: got %b want 1000", {pll_rst, retry_cnt});
    else passed++;
  endtask

  task automatic test_rst_in_release();
    bit hit;
    hit = 0;
    do_reset();
    pll_locked = 1'b1;
    for (int c = 0; c < 60 && !hit; c++) begin
      tick();
      checks++;
      if (obs !== expv())
        $display("FAIL rel_pre c%0d: got %b want %b", c, obs, expv());
      else passed++;
      hit = (m_mode == M_REL && m_age >= 1);
    end
    checks++;
    if (!hit) $display("FAIL rel_reach: got 0 want 1");
    else passed++;
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (obs !== {1'b1, {N_OUT{1'b1}}, 5'b0})
      $display("FAIL rel_async: got %b want %b", obs,
               {1'b1, {N_OUT{1'b1}}, 5'b0});
    else passed++;
    @(posedge refclk);
    #2 rst = 1'b0;
    for (int c = 0; c < 25; c++) begin
      tick();
      checks++;
      if (obs !== expv())
        $display("FAIL rel_redo c%0d: got %b want %b", c, obs, expv());
      else passed++;
    end
    checks++;
    if (ready !== 1'b1) $display("FAIL rel_ready: got %b want 1", ready);
    else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      tick();
      checks++;
      if (obs !== expv())
        $display("FAIL rand c%0d: got %b want %b", c, obs, expv());
      else passed++;
      if ($urandom_range(0, pll_locked ? 24 : 5) == 0)
        pll_locked = ~pll_locked;
      restart = ($urandom_range(0, 89) == 0);
    end
    restart = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    restart = 1'b0;
    pll_locked = 1'b0;
    test_reset();
    test_bringup();
    test_loss_in_run();
    test_glitch();
    test_fail_restart();
    test_restart_on_timeout();
    test_rst_in_release();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
